chip8_mem_ctrl: RTL and testbench

CHIP8_MEM_CTRL -- requirements
Module: chip8_mem_ctrl

---
 rtl/chip8_pkg.sv | 43 ++++
 rtl/chip8_ram.sv | 36 +++
 rtl/chip8_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_chip8_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// +---------------------------------------------------------------------------+
// | chip8_pkg -- shared sizes, hex font table and controller state encoding   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package chip8_pkg;

  localparam int          ADDR_W    = 12;
  localparam int          DATA_W    = 8;
  localparam logic [11:0] FONT_BASE = 12'h000;
  localparam int          FONT_LEN  = 80;

  // Glyphs 0-F, five rows each, left-aligned in the high nibble
  localparam logic [7:0] FONT_ROM [FONT_LEN] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RD_CPU = 2'd2,
    RD_VID = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/chip8_ram.sv
// +---------------------------------------------------------------------------+
// | chip8_ram -- single-port synchronous RAM, registered read data            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module chip8_ram #(
  parameter int ADDR_W = chip8_pkg::ADDR_W,
  parameter int DATA_W = chip8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // A write leaves rdata untouched so an ack in progress keeps its byte
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/chip8_mem_ctrl.sv
// +---------------------------------------------------------------------------+
// | chip8_mem_ctrl -- CPU/display arbiter over one RAM port, optional font     |
// | preload when CHIP8_FONT_PRELOAD_EN is defined.  Revision: 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

module chip8_mem_ctrl #(
  parameter int                ADDR_W    = chip8_pkg::ADDR_W,
  parameter int                DATA_W    = chip8_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] FONT_BASE = chip8_pkg::FONT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_read_addr,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_read_ack,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_write_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              vid_read,
  input  logic [ADDR_W-1:0] vid_read_addr,
  output logic [DATA_W-1:0] vid_read_data,
  output logic              vid_read_ack,
  output logic              init_done
);

  import chip8_pkg::*;

  state_t            state;
  state_t            state_nx;
  logic              rr_vid;
  logic              rr_vid_nx;
  logic              grant_cpu;
  logic              grant_vid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

`ifdef CHIP8_FONT_PRELOAD_EN
  logic [6:0] font_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_idx <= '0;
    end else if (state == INIT) begin
      font_idx <= font_idx + 7'd1;
    end else begin
      font_idx <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      rr_vid <= 1'b0;
    end else begin
      state  <= state_nx;
      rr_vid <= rr_vid_nx;
    end
  end

  // rr_vid set means the display wins the next tie
  assign grant_cpu = cpu_read && (!vid_read || !rr_vid);
  assign grant_vid = vid_read && (!cpu_read || rr_vid);

  always_comb begin
    state_nx  = state;
    rr_vid_nx = rr_vid;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_write_addr;
    ram_wdata = cpu_write_data;
    case (state)
      INIT: begin
`ifdef CHIP8_FONT_PRELOAD_EN
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = FONT_BASE + ADDR_W'(font_idx);
        ram_wdata = DATA_W'(FONT_ROM[font_idx]);
        if (font_idx == 7'(FONT_LEN - 1)) begin
          state_nx = IDLE;
        end
`else
        ram_addr = FONT_BASE;
        state_nx = IDLE;
`endif
      end
      IDLE: begin
        if (cpu_write) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end else if (grant_cpu) begin
          ram_en    = 1'b1;
          ram_addr  = cpu_read_addr;
          state_nx  = RD_CPU;
          rr_vid_nx = 1'b1;
        end else if (grant_vid) begin
          ram_en    = 1'b1;
          ram_addr  = vid_read_addr;
          state_nx  = RD_VID;
          rr_vid_nx = 1'b0;
        end
      end
      default: begin
        // The read already went out last cycle, so the port is free for a write
        if (cpu_write) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
        state_nx = IDLE;
      end
    endcase
  end

  chip8_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign cpu_read_ack  = (state == RD_CPU);
  assign vid_read_ack  = (state == RD_VID);
  assign cpu_read_data = cpu_read_ack ? ram_rdata : '0;
  assign vid_read_data = vid_read_ack ? ram_rdata : '0;
  assign init_done     = (state != INIT);

endmodule

`default_nettype wire

// File: tb/tb_chip8_mem_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_chip8_mem_ctrl -- directed scoreboard bench for chip8_mem_ctrl         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_chip8_mem_ctrl;

  // Ticks from the release edge to the first sample with init_done high
`ifdef CHIP8_FONT_PRELOAD_EN
  localparam int INIT_TICKS = 80;
`else
  localparam int INIT_TICKS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic [11:0] cpu_read_addr = '0;
  logic [7:0]  cpu_read_data;
  logic        cpu_read_ack;
  logic        cpu_write = 1'b0;
  logic [11:0] cpu_write_addr = '0;
  logic [7:0]  cpu_write_data = '0;
  logic        vid_read = 1'b0;
  logic [11:0] vid_read_addr = '0;
  logic [7:0]  vid_read_data;
  logic        vid_read_ack;
  logic        init_done;

  always #5 clk = ~clk;

  chip8_mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_read       (cpu_read),
    .cpu_read_addr  (cpu_read_addr),
    .cpu_read_data  (cpu_read_data),
    .cpu_read_ack   (cpu_read_ack),
    .cpu_write      (cpu_write),
    .cpu_write_addr (cpu_write_addr),
    .cpu_write_data (cpu_write_data),
    .vid_read       (vid_read),
    .vid_read_addr  (vid_read_addr),
    .vid_read_data  (vid_read_data),
    .vid_read_ack   (vid_read_ack),
    .init_done      (init_done)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] cpu_exp [$];
  logic [7:0] vid_exp [$];
  int         cpu_due [$];
  int         vid_due [$];
  bit         cpu_hold = 1'b0;
  bit         vid_hold = 1'b0;
  bit         prev_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and retire any ack against the scoreboard
  task automatic tick();
    logic any_ack;
    @(negedge clk);
    cyc++;
    any_ack = cpu_read_ack | vid_read_ack;
    if (any_ack) chk("ack_spacing", 32'(prev_ack), 32'd0);
    if (cpu_read_ack && vid_read_ack) chk("dual_ack", 32'(vid_read_ack), 32'd0);
    if (cpu_read_ack) begin
      if (cpu_exp.size() == 0) begin
        chk("cpu_unexpected_ack", 32'(cpu_read_ack), 32'd0);
      end else begin
        chk("cpu_data", 32'(cpu_read_data), 32'(cpu_exp.pop_front()));
        chk("cpu_ack_cycle", 32'(cyc), 32'(cpu_due.pop_front()));
      end
      if (!cpu_hold) cpu_read = 1'b0;
    end
    if (vid_read_ack) begin
      if (vid_exp.size() == 0) begin
        chk("vid_unexpected_ack", 32'(vid_read_ack), 32'd0);
      end else begin
        chk("vid_data", 32'(vid_read_data), 32'(vid_exp.pop_front()));
        chk("vid_ack_cycle", 32'(cyc), 32'(vid_due.pop_front()));
      end
      if (!vid_hold) vid_read = 1'b0;
    end
    prev_ack = any_ack;
  endtask

  // Run until every expected ack is retired, then one more cycle back to IDLE
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cpu_exp.size() + vid_exp.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(cpu_exp.size() + vid_exp.size()), 32'd0);
    cpu_exp.delete();
    vid_exp.delete();
    cpu_due.delete();
    vid_due.delete();
    cpu_read = 1'b0;
    vid_read = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    cpu_write      = 1'b1;
    cpu_write_addr = a;
    cpu_write_data = d;
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic rd_cpu(input logic [11:0] a, input logic [7:0] d);
    cpu_read      = 1'b1;
    cpu_read_addr = a;
    cpu_exp.push_back(d);
    cpu_due.push_back(cyc + 1);
    drain(10);
  endtask

  task automatic rd_vid(input logic [11:0] a, input logic [7:0] d);
    vid_read      = 1'b1;
    vid_read_addr = a;
    vid_exp.push_back(d);
    vid_due.push_back(cyc + 1);
    drain(10);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!init_done && n < 300);
  endtask

  initial begin
    int n;

    repeat (3) tick();
    chk("rst_cpu_ack", 32'(cpu_read_ack), 32'd0);
    chk("rst_vid_ack", 32'(vid_read_ack), 32'd0);
    chk("rst_cpu_data", 32'(cpu_read_data), 32'd0);
    chk("rst_vid_data", 32'(vid_read_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    rst_n = 1'b1;
`ifdef CHIP8_FONT_PRELOAD_EN
    repeat (40) tick();
    chk("init_mid", 32'(init_done), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("init_in_reset", 32'(init_done), 32'd0);
    rst_n = 1'b1;
`endif
    wait_init(n);
    chk("init_latency", 32'(n), 32'(INIT_TICKS));
    tick();

`ifdef CHIP8_FONT_PRELOAD_EN
    rd_cpu(12'h000, 8'hF0);
    rd_cpu(12'h04F, 8'h80);
`endif

    wr(12'h200, 8'hA2);
    rd_cpu(12'h200, 8'hA2);

    // Write and read of the same byte together: write wins, read one cycle later
    cpu_write      = 1'b1;
    cpu_write_addr = 12'h201;
    cpu_write_data = 8'h1E;
    cpu_read       = 1'b1;
    cpu_read_addr  = 12'h201;
    cpu_exp.push_back(8'h1E);
    cpu_due.push_back(cyc + 2);
    tick();
    cpu_write = 1'b0;
    drain(10);

    // Lone display read leaves the tie-break pointing at the CPU
    wr(12'h300, 8'h33);
    wr(12'h310, 8'h44);
    rd_vid(12'h310, 8'h44);

    cpu_hold      = 1'b1;
    vid_hold      = 1'b1;
    cpu_read      = 1'b1;
    cpu_read_addr = 12'h300;
    vid_read      = 1'b1;
    vid_read_addr = 12'h310;
    cpu_exp.push_back(8'h33); cpu_due.push_back(cyc + 1);
    vid_exp.push_back(8'h44); vid_due.push_back(cyc + 3);
    cpu_exp.push_back(8'h33); cpu_due.push_back(cyc + 5);
    vid_exp.push_back(8'h44); vid_due.push_back(cyc + 7);
    repeat (7) tick();
    cpu_hold = 1'b0;
    vid_hold = 1'b0;
    drain(6);

    wr(12'hFFF, 8'h5A);
    rd_cpu(12'hFFF, 8'h5A);

    wr(12'h123, 8'h7C);
    cpu_hold      = 1'b1;
    cpu_read      = 1'b1;
    cpu_read_addr = 12'h123;
    cpu_exp.push_back(8'h7C); cpu_due.push_back(cyc + 1);
    cpu_exp.push_back(8'h7C); cpu_due.push_back(cyc + 3);
    cpu_exp.push_back(8'h7C); cpu_due.push_back(cyc + 5);
    repeat (5) tick();
    cpu_hold = 1'b0;
    drain(6);

    // Write issued during the ack cycle of a read must land
    cpu_read      = 1'b1;
    cpu_read_addr = 12'h200;
    cpu_exp.push_back(8'hA2);
    cpu_due.push_back(cyc + 1);
    tick();
    cpu_write      = 1'b1;
    cpu_write_addr = 12'h202;
    cpu_write_data = 8'h99;
    tick();
    cpu_write = 1'b0;
    drain(6);
    rd_cpu(12'h202, 8'h99);

    // Reset in the middle of a display read, with requests made during INIT
    wr(12'h050, 8'h77);
    wr(12'h000, 8'hF0);
    vid_read      = 1'b1;
    vid_read_addr = 12'h000;
    @(posedge clk);
    #1;
    chk("mid_read_ack", 32'(vid_read_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(vid_read_ack), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    tick();
    rst_n          = 1'b1;
    cpu_write      = 1'b1;
    cpu_write_addr = 12'h050;
    cpu_write_data = 8'h11;
    n = 0;
    do begin
      tick();
      n++;
      cpu_write = 1'b0;
    end while (!init_done && n < 300);
    chk("init_latency_early_req", 32'(n), 32'(INIT_TICKS));
    vid_exp.push_back(8'hF0);
    vid_due.push_back(cyc + 1);
    drain(10);
    rd_cpu(12'h050, 8'h77);

    tick();
    chk("final_cpu_ack", 32'(cpu_read_ack), 32'd0);
    chk("final_vid_ack", 32'(vid_read_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
